// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit with the architectural HI/LO
//         registers of a 5-stage MIPS pipeline.
//
// mult/multu/div/divu are computed the moment they are accepted and parked
// in tmp_hi/tmp_lo. A down-counter then holds Busy high for a fixed number
// of cycles, and HI/LO are committed on the edge where Busy drops. Because
// of this, the visible timing matches an iterative unit, and the decode-stage
// stall logic only has to look at Start || Busy.
//
// Handshake (Start/Busy): an operation is accepted at a rising edge where
// Start==1, Busy==0 and MDUOp is 1..4. Busy is registered and goes high on
// the following cycle. It stays high for exactly N cycles (MULT_CYCLES or
// DIV_CYCLES). New HI/LO are visible in the same cycle that Busy returns
// low. Start while Busy==1 is dropped without any state change.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset
//   MDUOp  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none
//   Start  in   1   E-stage pulse for a valid mult/multu/div/divu
//   A      in   32  forwarded rs value
//   B      in   32  forwarded rt value
//   Busy   out  1   registered, high while an operation is in flight
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
//   Out    out  32  combinational mfhi/mflo read data (0 for other ops)
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // State
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      tmp_hi;
    logic [31:0]      tmp_lo;
    logic             tmp_wr;   // pending result must be committed

    // Operation decode
    logic is_mul;
    logic is_div;
    logic start_ok;

    assign is_mul   = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign start_ok = Start && !busy && (is_mul || is_div);

    // -----------------------------------------------------------------------
    // Multiplier: sign- or zero-extending both operands to 64 bits lets one
    // 64-bit product (low 64 bits) serve both mult and multu.
    // -----------------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    assign mul_signed = (MDUOp == OP_MULT);
    assign a_ext      = {(mul_signed ? {32{A[31]}} : 32'd0), A};
    assign b_ext      = {(mul_signed ? {32{B[31]}} : 32'd0), B};
    assign prod       = a_ext * b_ext;

    // -----------------------------------------------------------------------
    // Divider: signed division is done on magnitudes and the signs are fixed
    // afterwards. The quotient takes sign(A)^sign(B) and the remainder takes
    // sign(A). 0x80000000 / -1 falls out naturally as 0x80000000 rem 0. A zero
    // divisor is replaced by 1 so the arithmetic stays defined; its result is
    // never committed.
    // -----------------------------------------------------------------------
    logic        div_signed;
    logic        div_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_signed = (MDUOp == OP_DIV);
    assign div_zero   = (B == 32'd0);
    assign abs_a      = (div_signed && A[31]) ? (32'd0 - A) : A;
    assign abs_b      = (div_signed && B[31]) ? (32'd0 - B) : B;
    assign divisor    = div_zero ? 32'd1 : abs_b;
    assign uq         = abs_a / divisor;
    assign ur         = abs_a % divisor;
    assign quot       = (div_signed && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
    assign rem        = (div_signed && A[31]) ? (32'd0 - ur) : ur;

    // Result selection for the operation being accepted
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] res_cycles;

    always_comb begin
        res_hi     = prod[63:32];
        res_lo     = prod[31:0];
        res_wr     = 1'b1;
        res_cycles = CNT_W'(MULT_CYCLES);
        if (is_div) begin
            res_hi     = rem;
            res_lo     = quot;
            res_wr     = !div_zero;
            res_cycles = CNT_W'(DIV_CYCLES);
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer and HI/LO registers. Busy is itself the state: idle (accepts
    // Start and mthi/mtlo) or counting down toward the commit edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            count  <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            tmp_wr <= 1'b0;
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy   <= 1'b0;
                tmp_wr <= 1'b0;
                if (tmp_wr) begin
                    hi_q <= tmp_hi;
                    lo_q <= tmp_lo;
                end
            end
        end else if (start_ok) begin
            busy   <= 1'b1;
            count  <= res_cycles;
            tmp_hi <= res_hi;
            tmp_lo <= res_lo;
            tmp_wr <= res_wr;
        end else if (MDUOp == OP_MTHI) begin
            hi_q <= A;
        end else if (MDUOp == OP_MTLO) begin
            lo_q <= A;
        end
    end

    assign Busy = busy;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // mfhi/mflo read the committed registers with no added latency
    always_comb begin
        Out = 32'd0;
        case (MDUOp)
            OP_MFHI: Out = hi_q;
            OP_MFLO: Out = lo_q;
            default: Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  int errors = 0;
  int checks = 0;

  // expected completion: {busy_length[7:0], hi[31:0], lo[31:0]}
  logic [71:0] exp_q[$];

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .Out   (Out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Holds the inputs across exactly one rising edge, then returns idle at edge+1.
  task automatic drive_cycle(input logic [3:0] op, input logic st,
                             input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; Start = st; A = a; B = b;
    @(posedge clk); #1;
    MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int len, input logic [31:0] ehi, input logic [31:0] elo);
    exp_q.push_back({8'(len), ehi, elo});
    drive_cycle(op, 1'b1, a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: Busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    #1 reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic busy_q;
  int   busy_len;

  initial begin
    busy_q   = 1'b0;
    busy_len = 0;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        busy_q   = 1'b0;
        busy_len = 0;
      end else begin
        if (busy_q && !Busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: completion seen with no expected result (HI=0x%08h LO=0x%08h)", HI, LO);
          end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            check("done_len", 32'(busy_len), 32'(e[71:64]));
            check("done_hi", HI, e[63:32]);
            check("done_lo", LO, e[31:0]);
          end
          busy_len = 0;
        end
        if (Busy) busy_len = busy_q ? busy_len + 1 : 1;
        busy_q = Busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", 32'(Busy), 32'd0);
    check("init_hi", HI, 32'd0);
    check("init_lo", LO, 32'd0);
    check("init_out", Out, 32'd0);
    reset = 1'b1;

    // mthi then asynchronous mid-cycle reset
    drive_cycle(4'd7, 1'b0, 32'h99, 32'd0);
    check("mthi_99", HI, 32'h99);
    pulse_reset();

    // multiply cases
    start_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    wait_idle();
    start_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle();
    start_op(4'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
    wait_idle();

    // divide cases
    start_op(4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    wait_idle();
    start_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle();
    start_op(4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    wait_idle();
    start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    wait_idle();

    // divide by zero keeps HI/LO
    drive_cycle(4'd7, 1'b0, 32'h11, 32'd0);
    drive_cycle(4'd8, 1'b0, 32'h22, 32'd0);
    MDUOp = 4'd5; #1 check("mfhi_11", Out, 32'h11);
    MDUOp = 4'd6; #1 check("mflo_22", Out, 32'h22);
    MDUOp = 4'd0;
    start_op(4'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    wait_idle();
    start_op(4'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    wait_idle();

    // abort: reset during busy cycle 3, nothing is expected to complete
    drive_cycle(4'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_busy_before", 32'(Busy), 32'd1);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
    end

    // start while busy and mthi while busy are both ignored
    start_op(4'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);
    drive_cycle(4'd4, 1'b1, 32'd100, 32'd7);
    drive_cycle(4'd7, 1'b0, 32'h55, 32'd0);
    check("mthi_while_busy", HI, 32'd0);
    wait_idle();
    MDUOp = 4'd6; #1 check("mflo_after", Out, 32'd6);
    MDUOp = 4'd5; #1 check("mfhi_after", Out, 32'd0);
    MDUOp = 4'd3; #1 check("out_other_op", Out, 32'd0);
    MDUOp = 4'd0;

    // bubble: div opcode without Start does nothing
    drive_cycle(4'd3, 1'b0, 32'd9, 32'd3);
    check("bubble_busy", 32'(Busy), 32'd0);
    check("bubble_lo", LO, 32'd6);

    // mtlo visible next cycle through LO and Out
    drive_cycle(4'd8, 1'b0, 32'h0000_ABCD, 32'd0);
    check("mtlo_lo", LO, 32'h0000_ABCD);
    MDUOp = 4'd6; #1 check("mtlo_out", Out, 32'h0000_ABCD);
    MDUOp = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected completions never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
